// File: rtl/param_return_stack_if.sv
// Return-stack control bundle: opcode, write data, peek port and status.
// The control unit holds the master side; the stack holds the slave side.
interface param_return_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]       stackOP;
  logic [WIDTH-1:0] w;
  logic             clr_err;
  logic [IW-1:0]    peek_idx;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] peek_data;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output stackOP, w, clr_err, peek_idx,
    input  a, peek_data, count, empty, full,
    input  overflow, underflow
  );

  modport slave (
    input  stackOP, w, clr_err, peek_idx,
    output a, peek_data, count, empty, full,
    output overflow, underflow
  );
endinterface

// File: rtl/param_return_stack.sv
// Circular-buffer return-address stack with a peek port and sticky error flags.
// State advances on the falling clock edge.
module param_return_stack #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 64,
  parameter int OVF_WRAP = 0
) (
  input logic CLK,
  input logic reset,
  param_return_stack_if.slave bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_REPL = 2'd2;
  localparam logic [1:0] OP_POP  = 2'd3;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    tp, tp_n, tp_inc, tp_dec;
  logic [CW-1:0]    cnt, cnt_n;
  logic             ovf, udf;
  logic             is_empty, is_full;
  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic             set_o, set_u;
  logic [IW:0]      tp_x, pk_x, pk_pos;
  logic [IW-1:0]    rd_idx;
  logic             peek_ok;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CW'(DEPTH));

  // explicit compare-and-wrap so non-power-of-two depths stay correct
  assign tp_inc = (tp == IW'(DEPTH - 1)) ? '0 : tp + IW'(1);
  assign tp_dec = (tp == '0) ? IW'(DEPTH - 1) : tp - IW'(1);

  assign tp_x   = {1'b0, tp};
  assign pk_x   = {1'b0, bus.peek_idx};
  assign pk_pos = (pk_x > tp_x)
                ? tp_x + (IW+1)'(DEPTH) - pk_x
                : tp_x - pk_x;
  assign rd_idx = pk_pos[IW-1:0];

  assign peek_ok = {{CW{1'b0}}, bus.peek_idx}
                 < {{IW{1'b0}}, cnt};

  always_comb begin
    tp_n   = tp;
    cnt_n  = cnt;
    wr_en  = 1'b0;
    wr_idx = tp_inc;
    set_o  = 1'b0;
    set_u  = 1'b0;
    unique case (1'b1)
      (bus.stackOP == OP_PUSH): begin
        if (!is_full) begin
          tp_n  = tp_inc;
          cnt_n = cnt + CW'(1);
          wr_en = 1'b1;
        end else begin
          set_o = 1'b1;
          if (OVF_WRAP != 0) begin
            tp_n  = tp_inc;
            wr_en = 1'b1;
          end
        end
      end
      (bus.stackOP == OP_REPL): begin
        wr_en = 1'b1;
        if (is_empty) begin
          tp_n  = tp_inc;
          cnt_n = CW'(1);
        end else begin
          wr_idx = tp;
        end
      end
      (bus.stackOP == OP_POP): begin
        if (is_empty) begin
          set_u = 1'b1;
        end else begin
          tp_n  = tp_dec;
          cnt_n = cnt - CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(negedge CLK) begin
    if (reset) begin
      tp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      tp  <= tp_n;
      cnt <= cnt_n;
      ovf <= set_o | (ovf & ~bus.clr_err);
      udf <= set_u | (udf & ~bus.clr_err);
    end
  end

  always_ff @(negedge CLK) begin
    if (wr_en && !reset)
      mem[wr_idx] <= bus.w;
  end

  assign bus.a         = is_empty ? '0 : mem[tp];
  assign bus.peek_data = peek_ok ? mem[rd_idx] : '0;
  assign bus.count     = cnt;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf;
  assign bus.underflow = udf;
endmodule

// File: doc/param_return_stack.md
# param_return_stack

Parametrised return-address stack for the stack processor; successor to the fixed 16x64 return stack. Pointer-based storage with configurable width and depth, a replace-top operation, a random-access peek port, occupancy and full/empty status, sticky overflow/underflow error flags, and a selectable overflow policy (reject or wrap). It sits beside the register stack and is driven by the control unit's return-stack opcode.

## Interface

Parameters:
- WIDTH, 16, bits per entry.
- DEPTH, 64, number of entries (>= 2, any integer).
- OVF_WRAP, 0: 0 = push-when-full is rejected; 1 = push-when-full overwrites the oldest entry.

Ports:
- CLK  input  1  clock; all state changes on negative edge.
- reset  input  1  synchronous, active-high; sampled on negative edge of CLK.
- stackOP  input  2  0 = NOP, 1 = PUSH, 2 = REPLACE, 3 = POP.
- w  input  WIDTH  write data for PUSH/REPLACE.
- clr_err  input  1  clears sticky error flags.
- peek_idx  input  max(1,$clog2(DEPTH))  entry index, 0 = top.
- a  output  WIDTH  top of stack; 0 when empty.
- peek_data  output  WIDTH  entry at peek_idx; 0 when peek_idx >= count.
- count  output  $clog2(DEPTH+1)  number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; set by push-when-full.
- underflow  output  1  sticky; set by pop-when-empty.

## Operation

- Storage: DEPTH x WIDTH array used as a circular buffer; top pointer `tp` (index of top entry) plus `count`. Entry k below top is at (tp - k) mod DEPTH. No entry shifting.
- PUSH, not full: tp <= tp+1 mod DEPTH, mem[new tp] <= w, count+1.
- PUSH, full, OVF_WRAP=0: no state change; overflow <= 1.
- PUSH, full, OVF_WRAP=1: tp advances, mem[new tp] <= w (overwrites oldest); count stays DEPTH; overflow <= 1.
- REPLACE, not empty: mem[tp] <= w; count unchanged.
- REPLACE, empty: behaves as PUSH (count becomes 1); no flag.
- POP, not empty: tp <= tp-1 mod DEPTH, count-1. Vacated slot need not be cleared; reads beyond count are masked to 0.
- POP, empty: no state change; underflow <= 1.
- NOP: no state change.
- clr_err: clears overflow and underflow on the same edge unless that edge's op sets a flag; a flag-setting event wins over clr_err for that flag only.
- a and peek_data are combinational from current state (mem, tp, count, peek_idx).
- Pointer and count arithmetic wraps modulo DEPTH, with correct behaviour for non-power-of-two DEPTH (explicit compare-and-wrap, not bit truncation).

## Timing

- All updates on negedge CLK; outputs settle after that edge, stable for the following posedge consumer.
- Reset (on negedge with reset=1): tp=0, count=0, overflow=0, underflow=0; therefore a=0, peek_data=0, empty=1, full=0. Reset overrides any concurrent stackOP and clr_err. Memory contents need not be cleared (masked by count).
- Reset mid-sequence: state returns to empty on that edge; subsequent ops behave as after power-on reset.
- Latency: an op presented before negedge n is visible on a/count/flags immediately after negedge n. Push-then-pop on consecutive edges returns the pushed value after the first and the prior top after the second.
- No handshake; one op per cycle, every op completes in one cycle.

## Test plan

(WIDTH=16, DEPTH=4 unless noted.)
- Reset, PUSH 0x1111, 0x2222, 0x3333 -> a=0x3333, count=3, peek_idx=2 gives 0x1111, peek_idx=3 gives 0, empty=0, full=0.
- OVF_WRAP=0: PUSH 0x1111..0x4444 then PUSH 0x5555 -> a=0x4444, count=4, full=1, overflow=1; four POPs give a = 0x3333, 0x2222, 0x1111, 0, and empty=1.
- OVF_WRAP=1: PUSH 1,2,3,4,5 -> a=5, count=4, peek_idx=3 gives 2, overflow=1; POPs give a=4,3,2 then 0; fifth POP sets underflow=1.
- Empty POP -> underflow=1, count=0; POP on empty with clr_err=1 on the same edge -> underflow stays 1; clr_err alone with NOP -> overflow=0, underflow=0.
- PUSH 0xAAAA, REPLACE 0xBBBB -> a=0xBBBB, count=1; reset, REPLACE 0xCCCC -> a=0xCCCC, count=1, no flag; DEPTH=5 wrap run of 7 pushes -> count=5, a=last value, peek_idx=4 gives third value.
- PUSH 0x1234, 0x5678, then reset=1 with stackOP=PUSH, w=0x9999 -> count=0, a=0, flags 0; next PUSH 0x0001 -> a=0x0001, count=1.
